dds_phase_acc: RTL and testbench

DDS_PHASE_ACC -- requirements
Module: dds_phase_acc

---
 rtl/dds_phase_acc.sv | 84 ++++++++
 tb/tb_dds_phase_acc.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: DDS phase accumulator with a shadowed FTW that is applied on a wrap.
// Define SWEEP_EN to add the saturating FTW sweep ports sweep_step and sweep_lim.
module dds_phase_acc #(
    parameter int ACC_W = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             phase_clr,
    input  logic [ACC_W-1:0] ftw_in,
    input  logic             ftw_valid,
    output logic             ftw_ready,
    output logic [IDX_W-1:0] ctrl,
    output logic             wrap,
    output logic             pend
`ifdef SWEEP_EN
    ,
    input  logic [ACC_W-1:0] sweep_step,
    input  logic [ACC_W-1:0] sweep_lim
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [ACC_W-1:0] acc, active, shadow, active_nxt, shadow_nxt;
    logic [ACC_W:0]   sum;
    logic             carry, accept;

    assign sum       = {1'b0, acc} + {1'b0, active};
    assign carry     = en && !phase_clr && sum[ACC_W];
    assign pend      = state == PEND;
    assign ftw_ready = !pend;
    assign accept    = ftw_valid && ftw_ready;

`ifdef SWEEP_EN
    logic [ACC_W:0]   sweep_sum;
    logic [ACC_W-1:0] swept;
    assign sweep_sum = {1'b0, active} + {1'b0, sweep_step};
    assign swept     = sweep_sum > {1'b0, sweep_lim} ? sweep_lim : sweep_sum[ACC_W-1:0];
`endif

    always_comb begin
        state_nxt  = state;
        active_nxt = active;
        shadow_nxt = shadow;
        if (!en) begin
            state_nxt  = IDLE;
            active_nxt = pend ? shadow : (accept ? ftw_in : active);
        end else if (pend) begin
            // A zero FTW never wraps, so the shadow would otherwise wait forever
            if (carry || active == '0) begin
                active_nxt = shadow;
                state_nxt  = RUN;
            end
        end else begin
            state_nxt  = accept ? PEND : RUN;
            shadow_nxt = accept ? ftw_in : shadow;
`ifdef SWEEP_EN
            active_nxt = carry ? swept : active;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            active <= '0;
            shadow <= '0;
            ctrl   <= '0;
            wrap   <= 1'b0;
        end else begin
            state  <= state_nxt;
            active <= active_nxt;
            shadow <= shadow_nxt;
            acc    <= phase_clr ? '0 : (en ? sum[ACC_W-1:0] : acc);
            ctrl   <= acc[ACC_W-1 -: IDX_W];
            wrap   <= carry;
        end
    end
endmodule

// File: tb/tb_dds_phase_acc.sv
// tb_dds_phase_acc: directed self-checking bench for dds_phase_acc (ACC_W=16, IDX_W=4).
module tb_dds_phase_acc;
    logic        clk = 1'b0;
    logic        rst_n, en, phase_clr, ftw_valid;
    logic [15:0] ftw_in;
    logic        ftw_ready, wrap, pend;
    logic [3:0]  ctrl;
    int          compared = 0, mismatched = 0;
`ifdef SWEEP_EN
    logic [15:0] sweep_step = 16'h0000, sweep_lim = 16'hFFFF;
`endif

    dds_phase_acc #(.ACC_W(16), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr),
        .ftw_in(ftw_in), .ftw_valid(ftw_valid), .ftw_ready(ftw_ready),
        .ctrl(ctrl), .wrap(wrap), .pend(pend)
`ifdef SWEEP_EN
        , .sweep_step(sweep_step), .sweep_lim(sweep_lim)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; phase_clr = 1'b0; ftw_valid = 1'b0; ftw_in = '0;
        step; step;
        check("rst_ctrl", 32'(ctrl), 0);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_pend", 32'(pend), 0);
        check("rst_ready", 32'(ftw_ready), 1);
        rst_n = 1'b1;
        // Idle load of 0x1000, then run: ctrl 0..15,0 and one wrap at edge 16
        ftw_in = 16'h1000; ftw_valid = 1'b1;
        step;
        ftw_valid = 1'b0;
        check("idle_pend", 32'(pend), 0);
        en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step;
            check($sformatf("run_ctrl%0d", k), 32'(ctrl), 32'((k - 1) % 16));
            check($sformatf("run_wrap%0d", k), 32'(wrap), (k == 16) ? 1 : 0);
        end
        // Offer 0x2000 mid-period: held until the wrap at edge 32
        ftw_in = 16'h2000; ftw_valid = 1'b1;
        step;
        ftw_valid = 1'b0;
        check("shadow_pend", 32'(pend), 1);
        check("shadow_ready", 32'(ftw_ready), 0);
        for (int k = 19; k <= 31; k++) step;
        check("shadow_hold_pend", 32'(pend), 1);
        check("shadow_hold_wrap", 32'(wrap), 0);
        step;
        check("apply_wrap", 32'(wrap), 1);
        check("apply_pend", 32'(pend), 0);
        check("apply_ready", 32'(ftw_ready), 1);
        check("apply_ctrl", 32'(ctrl), 15);
        step; check("x2_ctrl0", 32'(ctrl), 0);
        step; check("x2_ctrl1", 32'(ctrl), 2);
        step; check("x2_ctrl2", 32'(ctrl), 4);
        // Zero active FTW: shadow applied on the next edge
        en = 1'b0; phase_clr = 1'b1; ftw_in = 16'h0000; ftw_valid = 1'b1;
        step;
        phase_clr = 1'b0; ftw_valid = 1'b0; en = 1'b1;
        step;
        ftw_in = 16'h4000; ftw_valid = 1'b1;
        step;
        ftw_valid = 1'b0;
        check("z_pend", 32'(pend), 1);
        step;
        check("z_pend_low", 32'(pend), 0);
        step; check("z_ctrl0", 32'(ctrl), 0);
        step; check("z_ctrl1", 32'(ctrl), 4);
        step; check("z_ctrl2", 32'(ctrl), 8);
        step; check("z_ctrl3", 32'(ctrl), 12);
        check("z_wrap", 32'(wrap), 1);
        // Clear at acc=0xF000 would otherwise carry
        en = 1'b0; phase_clr = 1'b1; ftw_in = 16'h1000; ftw_valid = 1'b1;
        step;
        phase_clr = 1'b0; ftw_valid = 1'b0; en = 1'b1;
        for (int k = 0; k < 15; k++) step;
        phase_clr = 1'b1;
        step;
        phase_clr = 1'b0;
        check("clr_wrap", 32'(wrap), 0);
        check("clr_ctrl_prev", 32'(ctrl), 15);
        step;
        check("clr_ctrl", 32'(ctrl), 0);
        check("clr_wrap2", 32'(wrap), 0);
        // Asynchronous reset while a shadow is pending
        ftw_in = 16'h3000; ftw_valid = 1'b1;
        step;
        ftw_valid = 1'b0;
        check("ar_pend_pre", 32'(pend), 1);
        rst_n = 1'b0;
        #1;
        check("ar_ctrl", 32'(ctrl), 0);
        check("ar_wrap", 32'(wrap), 0);
        check("ar_pend", 32'(pend), 0);
        check("ar_ready", 32'(ftw_ready), 1);
        #2;
        rst_n = 1'b1;
        step; step; step;
        check("ar_lost_ctrl", 32'(ctrl), 0);
        check("ar_lost_pend", 32'(pend), 0);
        check("ar_lost_wrap", 32'(wrap), 0);
        // First FTW after reset in RUN goes through the shadow
        ftw_in = 16'h8000; ftw_valid = 1'b1;
        step;
        ftw_valid = 1'b0;
        check("post_pend", 32'(pend), 1);
        step;
        check("post_pend_low", 32'(pend), 0);
        step; check("post_ctrl0", 32'(ctrl), 0);
        step;
        check("post_ctrl1", 32'(ctrl), 8);
        check("post_wrap", 32'(wrap), 1);
`ifdef SWEEP_EN
        // FTW 0x1000 -> 0x2000 (wrap 16) -> 0x3000 (wrap 24) -> holds (wraps 30, 35)
        en = 1'b0; phase_clr = 1'b1; ftw_in = 16'h1000; ftw_valid = 1'b1;
        step;
        phase_clr = 1'b0; ftw_valid = 1'b0; en = 1'b1;
        sweep_step = 16'h1000; sweep_lim = 16'h3000;
        for (int k = 1; k <= 35; k++) begin
            step;
            check($sformatf("sweep_wrap%0d", k), 32'(wrap),
                  (k == 16 || k == 24 || k == 30 || k == 35) ? 1 : 0);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
